// File: rtl/run_seq_ctrl.sv
// Purpose : upstream command sequencer for fsm_counter; runs one counted sequence per reset.
// Latency : cmd handshake at cycle 0 -> start in cycle 1 -> stop in cycle 3+tgt -> done_valid from cycle 5+tgt.
// Backpres: cmd_ready only in IDLE; the result is held in REPORT until done_ready, after which the block halts.
//
// Ports:
//    clk, rst                 clock (rising edge), asynchronous active-low reset
//    cmd_valid/cmd_ready      run command handshake, cmd_target sampled at the handshake
//    start, stop              control to fsm_counter (start registered, stop combinational)
//    counter                  fsm_counter.counter
//    done_valid/done_ready    result handshake, done_count carries the final counter value
//    busy, err, err_code      status: busy outside IDLE/HALT, sticky error with code
module run_seq_ctrl #(
   parameter int MIN_TGT = 5,
   parameter int MAX_TGT = 6,
   parameter int TIMEOUT = 12,
   parameter int TO_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_target,
   output logic       start,
   output logic       stop,
   input  logic [2:0] counter,
   output logic       done_valid,
   input  logic       done_ready,
   output logic [2:0] done_count,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_code
);

   localparam logic [2:0]      TGT_LO  = 3'(MIN_TGT);
   localparam logic [2:0]      TGT_HI  = 3'(MAX_TGT);
   // timer counts completed RUN cycles; the one that would make it reach
   // TIMEOUT without a stop is the timeout cycle.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   localparam logic [1:0] ERR_TGT = 2'd1;
   localparam logic [1:0] ERR_SEQ = 2'd2;
   localparam logic [1:0] ERR_TO  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_INIT,
      S_RUN,
      S_CHECK,
      S_REPORT,
      S_HALT
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      tgt, tgt_nxt;
   logic [2:0]      exp_cnt, exp_nxt;
   logic [TO_W-1:0] timer, timer_nxt;
   logic [2:0]      dcount, dcount_nxt;
   logic            err_q, err_nxt;
   logic [1:0]      code_q, code_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         tgt     <= '0;
         exp_cnt <= '0;
         timer   <= '0;
         dcount  <= '0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         state   <= state_nxt;
         tgt     <= tgt_nxt;
         exp_cnt <= exp_nxt;
         timer   <= timer_nxt;
         dcount  <= dcount_nxt;
         err_q   <= err_nxt;
         code_q  <= code_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tgt_nxt    = tgt;
      exp_nxt    = exp_cnt;
      timer_nxt  = timer;
      dcount_nxt = dcount;
      err_nxt    = err_q;
      code_nxt   = code_q;

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_target >= TGT_LO && cmd_target <= TGT_HI) begin
                  tgt_nxt   = cmd_target;
                  state_nxt = S_ARM;
               end else begin
                  err_nxt   = 1'b1;
                  code_nxt  = ERR_TGT;
                  state_nxt = S_HALT;
               end
            end
         end
         S_ARM: state_nxt = S_INIT;
         S_INIT: begin
            exp_nxt   = '0;
            timer_nxt = '0;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            // Mismatch is tested first so it wins over a coincident timeout.
            if (counter != exp_cnt) begin
               err_nxt   = 1'b1;
               code_nxt  = ERR_SEQ;
               state_nxt = S_HALT;
            end else begin
               exp_nxt   = exp_cnt + 3'd1;
               timer_nxt = timer + TO_ONE;
               if (counter == tgt) begin
                  state_nxt = S_CHECK;
               end else if (timer == TO_LAST) begin
                  err_nxt   = 1'b1;
                  code_nxt  = ERR_TO;
                  state_nxt = S_HALT;
               end
            end
         end
         S_CHECK: begin
            // Downstream takes one more step after seeing stop.
            if (counter == tgt + 3'd1) begin
               dcount_nxt = counter;
               state_nxt  = S_REPORT;
            end else begin
               err_nxt   = 1'b1;
               code_nxt  = ERR_SEQ;
               state_nxt = S_HALT;
            end
         end
         S_REPORT: begin
            if (done_ready) state_nxt = S_HALT;
         end
         S_HALT: state_nxt = S_HALT;  // fsm_counter never leaves DONE, only rst recovers
         default: state_nxt = S_IDLE;
      endcase
   end

   // All outputs decode the state register, so reset removes them asynchronously.
   assign cmd_ready  = (state == S_IDLE);
   assign start      = (state == S_ARM);
   assign stop       = (state == S_RUN) && (counter == tgt);
   assign done_valid = (state == S_REPORT);
   assign done_count = dcount;
   assign busy       = (state != S_IDLE) && (state != S_HALT);
   assign err        = err_q;
   assign err_code   = code_q;

endmodule

// File: doc/run_seq_ctrl.md
Name: run_seq_ctrl

Overview:
Upstream command sequencer for fsm_counter. Accepts one run command through a valid/ready handshake and pulses start. It tracks the downstream counter, drives stop when the requested target is reached, and checks the final count. It then returns the result through a second valid/ready handshake and flags protocol errors. Shares clk and rst with fsm_counter; its counter input connects to fsm_counter.counter.

Parameters:
MIN_TGT, 5, lowest legal stop target (inclusive)
MAX_TGT, 6, highest legal stop target (inclusive)
TIMEOUT, 12, max cycles spent in RUN before timeout error; must be > MAX_TGT+1
TO_W, 4, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (rst==0 resets immediately)
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_target  in  3  counter value at which stop is raised
start  out  1  one-cycle pulse to fsm_counter
stop  out  1  stop request to fsm_counter
counter  in  3  fsm_counter.counter
done_valid  out  1  result available
done_ready  in  1  result consumer ready
done_count  out  3  final counter value observed
busy  out  1  high in any state other than IDLE and HALT
err  out  1  sticky error flag
err_code  out  2  0 none, 1 illegal target, 2 sequence mismatch, 3 timeout

Behaviour:
- Reset (rst==0, async): state=IDLE; tgt, exp and timer=0; all outputs 0 except cmd_ready=1; err_code=0.
- cmd_ready = (state==IDLE). Accept on cmd_valid && cmd_ready at a rising edge.
- IDLE, accept, MIN_TGT<=cmd_target<=MAX_TGT: latch tgt; go to ARM.
- IDLE, accept, target out of range: err=1, err_code=1; go to HALT. start is never raised.
- ARM (1 cycle): start=1 (registered; high only in this cycle); go to INIT.
- INIT (1 cycle): downstream is in its INIT state. Clear exp and timer; go to RUN.
- RUN:
  - Every cycle, compare counter with exp. If counter!=exp: err_code=2, go to HALT.
  - Otherwise exp<=exp+1 (3-bit wrap) and timer<=timer+1.
  - stop = (state==RUN) && (counter==tgt) is combinational, so it is high in exactly one cycle.
  - In the stop cycle, go to CHECK.
  - If timer reaches TIMEOUT before the stop cycle: err_code=3, go to HALT.
  - Mismatch takes priority over timeout.
- CHECK (1 cycle): require counter == tgt+1 (3-bit). If equal, latch done_count=counter and go to REPORT. Otherwise err_code=2, go to HALT.
- REPORT: done_valid=1 and done_count held stable until done_valid && done_ready; then go to HALT. done_valid drops in the cycle after the handshake.
- HALT: terminal, because fsm_counter never leaves its DONE state. cmd_ready=0, busy=0. Only rst exits HALT.
- Errors:
  - err is set together with the error's err_code.
  - err and err_code are sticky until rst.
  - The first error wins; later error conditions cannot occur, since HALT is absorbing.
- Command latency: handshake at cycle 0 -> start in cycle 1 -> downstream counter=0 in cycle 3 -> stop in cycle 3+tgt -> CHECK in cycle 4+tgt -> done_valid from cycle 5+tgt.
- cmd_target is sampled only at the handshake; later changes are ignored.
- cmd_valid while busy or in HALT is not accepted (cmd_ready=0).
- Reset mid-operation: immediate return to IDLE. Any in-flight start or stop is removed asynchronously.

Test Plan:
- Reset with rst=0, then release; drive cmd_valid=1, cmd_target=5 at cycle 0 -> start=1 only in cycle 1; stop=1 only in cycle 8 (counter=5); done_valid from cycle 10 with done_count=6; err=0.
- cmd_target=6 with done_ready held 0 for 3 cycles -> stop in cycle 9; done_valid and done_count=7 held stable 3 cycles; after the handshake, HALT with cmd_ready=0, busy=0.
- cmd_target=4 (also repeat with 7) -> no start pulse; err=1, err_code=1; HALT.
- Model forces counter to 2 when exp=1 during RUN -> err_code=2; stop never raised; HALT.
- Model freezes counter at 3 with cmd_target=5 -> mismatch on the next cycle, err_code=2. Separately, a model that increments normally but TIMEOUT is overridden to 4 -> err_code=3.
- Drop rst to 0 in cycle 6 of a target=5 run -> outputs return to reset values immediately; after release, a new target=6 command completes with done_count=7.
